dmem_sram_bridge: RTL and testbench
===================================

// Module: dmem_sram_bridge
// PURPOSE
//  Data-memory slave feeding the microcoded RV32IMF core's dmem port: accepts one request at a time on the
//  valid/ready channel, performs sub-word lane alignment, drives a single-port synchronous SRAM, and returns
//  load data on dmem_resp_valid/dmem_resp_data. Sits directly downstream of the CPU's dmem_req_* outputs.
// PARAMETERS
//  ADDR_WIDTH    12  SRAM word-address bits (capacity = 4*2^ADDR_WIDTH bytes)
//  SRAM_LATENCY  1   cycles from sram_ce to valid sram_rdata (legal: 1..3)
// PORTS
//  clock           in   1   single clock, all state on rising edge
//  reset_n         in   1   synchronous, active-low reset
//  dmem_req_valid  in   1   CPU request valid
//  dmem_req_ready  out  1   bridge can accept a request this cycle
//  dmem_req_we     in   1   1 = store, 0 = load
//  dmem_req_addr   in   32  byte address
//  dmem_req_data   in   32  store data, right-justified
//  dmem_req_size_0 in   1   size LSB
//  dmem_req_size_1 in   1   size MSB; {size_1,size_0}: 00 byte, 01 half, 10 word, 11 reserved
//  dmem_resp_valid out  1   one-cycle pulse, load data valid (no resp_ready: always consumed)
//  dmem_resp_data  out  32  load data, right-justified, zero-extended (CPU sign-extends)
//  sram_ce         out  1   SRAM chip enable
//  sram_we         out  1   SRAM write enable
//  sram_addr       out  ADDR_WIDTH  word address = dmem_req_addr[ADDR_WIDTH+1:2]
//  sram_wmask      out  4   byte-lane write mask
//  sram_wdata      out  32  lane-replicated store data
//  sram_rdata      in   32  SRAM read data
//  fault_valid     out  1   one-cycle pulse: misaligned or reserved-size request
//  fault_addr      out  32  address of most recent faulting request (holds until next fault)
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE; dmem_req_ready=1 after reset; dmem_resp_valid, sram_ce, sram_we,
//   fault_valid =0; sram_wmask=0; dmem_resp_data, fault_addr =0. Reset mid-operation abandons in-flight access.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. dmem_req_ready = (state==IDLE), combinational from state only.
//  IDLE: on valid&&ready latch we/addr/data/size. Legal -> ISSUE. Fault -> (load: RESP, store: IDLE).
//  Fault = size 11, half with addr[0]=1, or word with addr[1:0]!=0. Fault: no SRAM access; fault_valid pulses
//   the cycle after acceptance; fault_addr updated same cycle; faulting load returns dmem_resp_data=0.
//  ISSUE (1 cycle): sram_ce=1, sram_addr/wmask/wdata from latched request. Store: sram_we=1, -> IDLE.
//   Load: sram_we=0, wmask=0, -> WAIT.
//  WAIT: counter counts SRAM_LATENCY cycles after ISSUE; on last, capture sram_rdata, extract lane -> RESP.
//  RESP: dmem_resp_valid=1 for exactly one cycle with registered data -> IDLE.
//  Latency: load accepted at T -> dmem_resp_valid at T+2+SRAM_LATENCY; next accept at T+3+SRAM_LATENCY.
//   Store accepted at T -> SRAM write at T+1, ready again at T+2. Stores never pulse dmem_resp_valid.
//  Lanes: byte mask 0001<<addr[1:0], wdata = {4{data[7:0]}}; half mask 0011<<addr[1:0], wdata = {2{data[15:0]}};
//   word mask 1111. Load extract: byte = rdata >> 8*addr[1:0] & 0xFF; half = rdata >> 8*addr[1:0] & 0xFFFF.
//  Address bits [31:ADDR_WIDTH+2] ignored: accesses alias modulo SRAM size (wrap-around, no fault).
//  sram_* outputs registered; sram_ce/sram_we low in every state but ISSUE.
//  Inputs while ready=0 are ignored; no request is queued or lost from the bridge's view.
// STRUCTURE
//  Package dmem_pkg: dmem_size_e {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD}; bridge_state_e {IDLE, ISSUE, WAIT, RESP};
//   functions lane_mask(size, off), is_misaligned(size, off).
//  Sub-module dmem_lane_align (combinational): size+offset+wdata -> wmask/wdata; size+offset+rdata -> load data.
//  Top: FSM, request latch, latency counter ($clog2(SRAM_LATENCY+1) bits), response and fault registers.
// TESTING
//  1 Reset: hold reset_n=0 3 cycles with req_valid=1 -> no sram_ce, resp_valid=0, ready=1 after release.
//  2 Word store addr 0x100 data 0xDEADBEEF then word load 0x100 -> sram_addr=0x040 wmask=1111;
//    resp_valid exactly at T+3 (LAT=1), data 0xDEADBEEF.
//  3 Byte store 0xA5 to 0x103 over 0x11223344 -> wmask=1000 wdata=0xA5A5A5A5; word load 0xA5223344;
//    byte load 0x103 -> 0x000000A5; half load 0x102 -> 0x0000A522.
//  4 Half load addr 0x101 -> no sram_ce, fault_valid one cycle, fault_addr=0x101, resp data 0;
//    size 11 store -> fault, no resp_valid.
//  5 Aliasing: word store 0x0000_0004 then load 0x0000_4004 (ADDR_WIDTH=12) -> same data returned.
//  6 reset_n=0 during WAIT (SRAM_LATENCY=3) -> no resp_valid ever issued; next load returns correct data.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and lane helpers for the dmem SRAM bridge
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } bridge_state_e;

  function automatic logic [3:0] lane_mask(dmem_size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Reserved size is folded in here so the bridge has a single fault test.
  function automatic logic is_misaligned(dmem_size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram_bridge_if.sv
// rtl/dmem_sram_bridge_if.sv - CPU dmem request/response and SRAM bus bundle
interface dmem_sram_bridge_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic                  dmem_req_we;
  logic [31:0]           dmem_req_addr;
  logic [31:0]           dmem_req_data;
  logic                  dmem_req_size_0;
  logic                  dmem_req_size_1;
  logic                  dmem_resp_valid;
  logic [31:0]           dmem_resp_data;
  logic                  sram_ce;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [3:0]            sram_wmask;
  logic [31:0]           sram_wdata;
  logic [31:0]           sram_rdata;
  logic                  fault_valid;
  logic [31:0]           fault_addr;

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_data,
    input  dmem_req_size_0, dmem_req_size_1, sram_rdata,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_data,
    output sram_ce, sram_we, sram_addr, sram_wmask, sram_wdata,
    output fault_valid, fault_addr
  );

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_data,
    output dmem_req_size_0, dmem_req_size_1, sram_rdata,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_data,
    input  sram_ce, sram_we, sram_addr, sram_wmask, sram_wdata,
    input  fault_valid, fault_addr
  );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and load extraction
module dmem_lane_align
  import dmem_pkg::*;
(
  input  dmem_size_e  i_wr_size,
  input  logic [1:0]  i_wr_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  input  dmem_size_e  i_rd_size,
  input  logic [1:0]  i_rd_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);
  logic [31:0] w_shifted;

  always_comb begin
    o_wmask = lane_mask(i_wr_size, i_wr_off);
    // Replicated data lets the mask alone pick the lane.
    case (i_wr_size)
      SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
      SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase

    w_shifted = i_rdata >> {i_rd_off, 3'b000};
    case (i_rd_size)
      SZ_BYTE: o_rdata = {24'h000000, w_shifted[7:0]};
      SZ_HALF: o_rdata = {16'h0000, w_shifted[15:0]};
      default: o_rdata = i_rdata;
    endcase
  end
endmodule

// File: rtl/dmem_sram_bridge.sv
// rtl/dmem_sram_bridge.sv - one-at-a-time dmem slave driving a single-port synchronous SRAM
module dmem_sram_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int SRAM_LATENCY = 1
) (
  input logic                clock,
  input logic                reset_n,
  dmem_sram_bridge_if.slave  bus
);
  localparam int CW = $clog2(SRAM_LATENCY + 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(SRAM_LATENCY);

  bridge_state_e         r_state;
  dmem_size_e            r_size;
  logic [1:0]            r_off;
  logic [CW-1:0]         r_cnt;
  logic                  r_resp_valid;
  logic [31:0]           r_resp_data;
  logic                  r_sram_ce;
  logic                  r_sram_we;
  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [3:0]            r_sram_wmask;
  logic [31:0]           r_sram_wdata;
  logic                  r_fault_valid;
  logic [31:0]           r_fault_addr;

  dmem_size_e  w_size;
  logic [1:0]  w_off;
  logic        w_fault;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_size  = dmem_size_e'({bus.dmem_req_size_1, bus.dmem_req_size_0});
  assign w_off   = bus.dmem_req_addr[1:0];
  assign w_fault = is_misaligned(w_size, w_off);

  dmem_lane_align u_lane_align (
    .i_wr_size (w_size),
    .i_wr_off  (w_off),
    .i_wdata   (bus.dmem_req_data),
    .o_wmask   (w_wmask),
    .o_wdata   (w_wdata),
    .i_rd_size (r_size),
    .i_rd_off  (r_off),
    .i_rdata   (bus.sram_rdata),
    .o_rdata   (w_load_data)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_size        <= SZ_BYTE;
      r_off         <= 2'b00;
      r_cnt         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= 32'h0;
      r_sram_ce     <= 1'b0;
      r_sram_we     <= 1'b0;
      r_sram_addr   <= '0;
      r_sram_wmask  <= 4'b0000;
      r_sram_wdata  <= 32'h0;
      r_fault_valid <= 1'b0;
      r_fault_addr  <= 32'h0;
    end else begin
      r_sram_ce     <= 1'b0;
      r_sram_we     <= 1'b0;
      r_sram_wmask  <= 4'b0000;
      r_resp_valid  <= 1'b0;
      r_fault_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.dmem_req_valid) begin
            r_size <= w_size;
            r_off  <= w_off;
            if (w_fault) begin
              r_fault_valid <= 1'b1;
              r_fault_addr  <= bus.dmem_req_addr;
              if (!bus.dmem_req_we) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= 32'h0;
                r_state      <= RESP;
              end
            end else begin
              // SRAM strobes are launched straight from the request so ISSUE sees them.
              r_state      <= ISSUE;
              r_sram_ce    <= 1'b1;
              r_sram_we    <= bus.dmem_req_we;
              r_sram_addr  <= bus.dmem_req_addr[ADDR_WIDTH+1:2];
              r_sram_wmask <= bus.dmem_req_we ? w_wmask : 4'b0000;
              r_sram_wdata <= w_wdata;
            end
          end
        end
        ISSUE: begin
          r_cnt   <= CW'(1);
          r_state <= r_sram_we ? IDLE : WAIT;
        end
        WAIT: begin
          if (r_cnt == LAT_LAST) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_load_data;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dmem_req_ready  = (r_state == IDLE);
  assign bus.dmem_resp_valid = r_resp_valid;
  assign bus.dmem_resp_data  = r_resp_data;
  assign bus.sram_ce         = r_sram_ce;
  assign bus.sram_we         = r_sram_we;
  assign bus.sram_addr       = r_sram_addr;
  assign bus.sram_wmask      = r_sram_wmask;
  assign bus.sram_wdata      = r_sram_wdata;
  assign bus.fault_valid     = r_fault_valid;
  assign bus.fault_addr      = r_fault_addr;
endmodule

// File: tb/tb_dmem_sram_bridge.sv
// tb/tb_dmem_sram_bridge.sv - directed bench for dmem_sram_bridge at SRAM latency 1 and 3
module tb_dmem_sram_bridge;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        sel;
  logic        drv_valid;
  logic        drv_we;
  logic [31:0] drv_addr;
  logic [31:0] drv_data;
  logic [1:0]  drv_size;

  int errors = 0;
  int checks = 0;

  dmem_sram_bridge_if #(.ADDR_WIDTH(12)) bus_a ();
  dmem_sram_bridge_if #(.ADDR_WIDTH(12)) bus_b ();

  dmem_sram_bridge #(.ADDR_WIDTH(12), .SRAM_LATENCY(1)) u_dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  dmem_sram_bridge #(.ADDR_WIDTH(12), .SRAM_LATENCY(3)) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  assign bus_a.dmem_req_valid  = drv_valid & ~sel;
  assign bus_b.dmem_req_valid  = drv_valid & sel;
  assign bus_a.dmem_req_we     = drv_we;
  assign bus_b.dmem_req_we     = drv_we;
  assign bus_a.dmem_req_addr   = drv_addr;
  assign bus_b.dmem_req_addr   = drv_addr;
  assign bus_a.dmem_req_data   = drv_data;
  assign bus_b.dmem_req_data   = drv_data;
  assign bus_a.dmem_req_size_0 = drv_size[0];
  assign bus_b.dmem_req_size_0 = drv_size[0];
  assign bus_a.dmem_req_size_1 = drv_size[1];
  assign bus_b.dmem_req_size_1 = drv_size[1];

  // SRAM models: A returns data one cycle after ce, B three cycles after.
  logic [31:0] mem_a [0:4095];
  logic [31:0] mem_b [0:4095];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [0:2];

  function automatic logic [31:0] expand(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  always @(posedge clock) begin
    if (bus_a.sram_ce) begin
      if (bus_a.sram_we)
        mem_a[bus_a.sram_addr] <= (mem_a[bus_a.sram_addr] & ~expand(bus_a.sram_wmask))
                                | (bus_a.sram_wdata & expand(bus_a.sram_wmask));
      else
        pipe_a <= mem_a[bus_a.sram_addr];
    end
    if (bus_b.sram_ce) begin
      if (bus_b.sram_we)
        mem_b[bus_b.sram_addr] <= (mem_b[bus_b.sram_addr] & ~expand(bus_b.sram_wmask))
                                | (bus_b.sram_wdata & expand(bus_b.sram_wmask));
      else
        pipe_b[0] <= mem_b[bus_b.sram_addr];
    end
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign bus_a.sram_rdata = pipe_a;
  assign bus_b.sram_rdata = pipe_b[2];

  logic        obs_ready, obs_resp, obs_ce, obs_we, obs_fault;
  logic [31:0] obs_rdata, obs_wdata, obs_fault_addr;
  logic [11:0] obs_saddr;
  logic [3:0]  obs_wmask;

  assign obs_ready      = sel ? bus_b.dmem_req_ready  : bus_a.dmem_req_ready;
  assign obs_resp       = sel ? bus_b.dmem_resp_valid : bus_a.dmem_resp_valid;
  assign obs_rdata      = sel ? bus_b.dmem_resp_data  : bus_a.dmem_resp_data;
  assign obs_ce         = sel ? bus_b.sram_ce         : bus_a.sram_ce;
  assign obs_we         = sel ? bus_b.sram_we         : bus_a.sram_we;
  assign obs_saddr      = sel ? bus_b.sram_addr       : bus_a.sram_addr;
  assign obs_wmask      = sel ? bus_b.sram_wmask      : bus_a.sram_wmask;
  assign obs_wdata      = sel ? bus_b.sram_wdata      : bus_a.sram_wdata;
  assign obs_fault      = sel ? bus_b.fault_valid     : bus_a.fault_valid;
  assign obs_fault_addr = sel ? bus_b.fault_addr      : bus_a.fault_addr;

  // Observations of one request; k counts negedges after the accepting posedge, from 0.
  logic [31:0] o_rdata, o_wdata;
  logic [11:0] o_saddr;
  logic [3:0]  o_wmask;
  logic        o_we_seen;
  int          o_resp_k, o_resp_cnt, o_ce_cnt, o_fault_cnt, o_ready_k;

  task automatic run_req(input logic s, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] size);
    int guard = 0;
    o_rdata = 32'hFFFF_FFFF; o_wdata = 32'h0; o_saddr = 12'hFFF; o_wmask = 4'hx;
    o_we_seen = 1'bx; o_resp_k = -1; o_resp_cnt = 0; o_ce_cnt = 0; o_fault_cnt = 0; o_ready_k = -1;
    @(negedge clock);
    sel = s;
    while (!obs_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    checks++;
    if (!obs_ready) begin
      errors++;
      $display("FAIL ready_timeout addr=%h got ready=%b want 1", addr, obs_ready);
    end
    drv_we = we; drv_addr = addr; drv_data = data; drv_size = size; drv_valid = 1'b1;
    @(negedge clock);
    drv_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (obs_ce) begin
        o_ce_cnt++; o_wmask = obs_wmask; o_wdata = obs_wdata; o_saddr = obs_saddr; o_we_seen = obs_we;
      end
      if (obs_fault) o_fault_cnt++;
      if (obs_resp) begin
        o_resp_cnt++;
        if (o_resp_k < 0) o_resp_k = k;
        o_rdata = obs_rdata;
      end
      if (obs_ready && o_ready_k < 0) o_ready_k = k;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; reset_n = 1'b0;
    drv_we = 1'b0; drv_addr = 32'h0; drv_data = 32'h0; drv_size = 2'b10; drv_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (obs_ce !== 1'b0 || obs_resp !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet cycle=%0d got ce=%b resp=%b want 0 0", i, obs_ce, obs_resp);
      end
    end
    reset_n = 1'b1; drv_valid = 1'b0;
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b want=1", obs_ready);
    end
    checks++;
    if (obs_wmask !== 4'h0 || obs_rdata !== 32'h0 || obs_fault_addr !== 32'h0 || obs_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got wmask=%h rdata=%h faddr=%h fault=%b want 0 0 0 0",
               obs_wmask, obs_rdata, obs_fault_addr, obs_fault);
    end
  endtask

  task automatic test_word();
    run_req(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 2'b10);
    checks++;
    if (o_ce_cnt !== 1 || o_we_seen !== 1'b1 || o_saddr !== 12'h040 || o_wmask !== 4'hF || o_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL word_store got ce=%0d we=%b addr=%h mask=%h wdata=%h want 1 1 040 f deadbeef",
               o_ce_cnt, o_we_seen, o_saddr, o_wmask, o_wdata);
    end
    checks++;
    if (o_resp_cnt !== 0 || o_ready_k !== 1) begin
      errors++; $display("FAIL word_store_timing got resp=%0d ready_k=%0d want 0 1", o_resp_cnt, o_ready_k);
    end
    run_req(1'b0, 1'b0, 32'h100, 32'h0, 2'b10);
    checks++;
    if (o_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL word_load_data got=%h want=deadbeef", o_rdata);
    end
    checks++;
    if (o_resp_k !== 2 || o_resp_cnt !== 1 || o_ready_k !== 3 || o_we_seen !== 1'b0 || o_wmask !== 4'h0) begin
      errors++;
      $display("FAIL word_load_timing got resp_k=%0d resp=%0d ready_k=%0d we=%b mask=%h want 2 1 3 0 0",
               o_resp_k, o_resp_cnt, o_ready_k, o_we_seen, o_wmask);
    end
  endtask

  task automatic test_lanes();
    run_req(1'b0, 1'b1, 32'h100, 32'h1122_3344, 2'b10);
    run_req(1'b0, 1'b1, 32'h103, 32'h0000_00A5, 2'b00);
    checks++;
    if (o_wmask !== 4'b1000 || o_wdata !== 32'hA5A5_A5A5 || o_saddr !== 12'h040) begin
      errors++;
      $display("FAIL byte_store got mask=%b wdata=%h addr=%h want 1000 a5a5a5a5 040", o_wmask, o_wdata, o_saddr);
    end
    run_req(1'b0, 1'b0, 32'h100, 32'h0, 2'b10);
    checks++;
    if (o_rdata !== 32'hA522_3344) begin
      errors++; $display("FAIL merged_word got=%h want=a5223344", o_rdata);
    end
    run_req(1'b0, 1'b0, 32'h103, 32'h0, 2'b00);
    checks++;
    if (o_rdata !== 32'h0000_00A5) begin
      errors++; $display("FAIL byte_load got=%h want=000000a5", o_rdata);
    end
    run_req(1'b0, 1'b0, 32'h102, 32'h0, 2'b01);
    checks++;
    if (o_rdata !== 32'h0000_A522) begin
      errors++; $display("FAIL half_load got=%h want=0000a522", o_rdata);
    end
    run_req(1'b0, 1'b1, 32'h102, 32'hFFFF_BEEF, 2'b01);
    checks++;
    if (o_wmask !== 4'b1100 || o_wdata !== 32'hBEEF_BEEF) begin
      errors++; $display("FAIL half_store got mask=%b wdata=%h want 1100 beefbeef", o_wmask, o_wdata);
    end
  endtask

  task automatic test_fault();
    run_req(1'b0, 1'b0, 32'h101, 32'h0, 2'b01);
    checks++;
    if (o_ce_cnt !== 0 || o_fault_cnt !== 1 || obs_fault_addr !== 32'h101) begin
      errors++;
      $display("FAIL half_misaligned got ce=%0d faults=%0d faddr=%h want 0 1 00000101",
               o_ce_cnt, o_fault_cnt, obs_fault_addr);
    end
    checks++;
    if (o_resp_cnt !== 1 || o_rdata !== 32'h0) begin
      errors++; $display("FAIL fault_load_resp got resp=%0d data=%h want 1 0", o_resp_cnt, o_rdata);
    end
    run_req(1'b0, 1'b1, 32'h200, 32'h55, 2'b11);
    checks++;
    if (o_ce_cnt !== 0 || o_fault_cnt !== 1 || o_resp_cnt !== 0 || obs_fault_addr !== 32'h200) begin
      errors++;
      $display("FAIL rsvd_store got ce=%0d faults=%0d resp=%0d faddr=%h want 0 1 0 00000200",
               o_ce_cnt, o_fault_cnt, o_resp_cnt, obs_fault_addr);
    end
    run_req(1'b0, 1'b1, 32'h102, 32'h77, 2'b10);
    checks++;
    if (o_ce_cnt !== 0 || o_fault_cnt !== 1 || obs_fault_addr !== 32'h102) begin
      errors++;
      $display("FAIL word_misaligned got ce=%0d faults=%0d faddr=%h want 0 1 00000102",
               o_ce_cnt, o_fault_cnt, obs_fault_addr);
    end
  endtask

  task automatic test_alias();
    run_req(1'b0, 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 2'b10);
    run_req(1'b0, 1'b0, 32'h0000_4004, 32'h0, 2'b10);
    checks++;
    if (o_rdata !== 32'hCAFE_F00D || o_saddr !== 12'h001 || o_fault_cnt !== 0) begin
      errors++;
      $display("FAIL alias got data=%h addr=%h faults=%0d want cafef00d 001 0", o_rdata, o_saddr, o_fault_cnt);
    end
  endtask

  task automatic test_reset_in_wait();
    int resp_seen = 0;
    run_req(1'b1, 1'b1, 32'h10, 32'h1234_5678, 2'b10);
    @(negedge clock);
    sel = 1'b1;
    drv_we = 1'b0; drv_addr = 32'h10; drv_size = 2'b10; drv_valid = 1'b1;
    @(negedge clock);
    drv_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++; $display("FAIL lat3_busy got ready=%b want 0", obs_ready);
    end
    reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) reset_n = 1'b1;
      @(negedge clock);
      if (obs_resp) resp_seen++;
    end
    checks++;
    if (resp_seen !== 0 || obs_ready !== 1'b1) begin
      errors++; $display("FAIL wait_reset got resp=%0d ready=%b want 0 1", resp_seen, obs_ready);
    end
    run_req(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    checks++;
    if (o_rdata !== 32'h1234_5678 || o_resp_k !== 4 || o_resp_cnt !== 1 || o_ready_k !== 5) begin
      errors++;
      $display("FAIL lat3_load got data=%h resp_k=%0d resp=%0d ready_k=%0d want 12345678 4 1 5",
               o_rdata, o_resp_k, o_resp_cnt, o_ready_k);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_fault();
    test_alias();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
